ecg_sample_player: RTL
======================

ECG_SAMPLE_PLAYER -- requirements
Module: ecg_sample_player

Interface
REQ-001 Parameter LENGTH, 21600, number of samples in recording memory.
REQ-002 Parameter DATA_WIDTH, 11, sample width in bits.
REQ-003 Parameter ADDR_WIDTH, $clog2(LENGTH), memory address width.
REQ-004 Parameter CLK_DIV, 277778, clock cycles per sample period (100 MHz / 360 Hz); legal range 3..2^24-1.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse, begin playback from index 0.
REQ-008 stop  input  1  one-cycle pulse, abort playback.
REQ-009 loop_en  input  1  wrap to index 0 after last sample instead of finishing.
REQ-010 mem_rd_en  output  1  memory read strobe.
REQ-011 mem_addr  output  ADDR_WIDTH  memory read address.
REQ-012 mem_rdata  input  DATA_WIDTH  read data, valid exactly one cycle after mem_rd_en.
REQ-013 sample_data  output  DATA_WIDTH  current sample to consumer.
REQ-014 sample_valid  output  1  sample_data valid.
REQ-015 sample_ready  input  1  consumer accepts sample.
REQ-016 sample_idx  output  ADDR_WIDTH  index of current/next sample.
REQ-017 busy  output  1  playback active (any state except IDLE, DONE).
REQ-018 done  output  1  playback finished (DONE state).

Function
REQ-019 FSM states IDLE, WAIT_TICK, READ, HOLD, DONE.
REQ-020 Rate divider counts 0..CLK_DIV-1 while busy; tick = one-cycle strobe at terminal count; counter cleared on start and in IDLE/DONE.
REQ-021 IDLE/DONE + start -> WAIT_TICK, sample_idx=0, divider=0, done=0.
REQ-022 WAIT_TICK + tick -> READ; mem_rd_en=1, mem_addr=sample_idx during READ only (one cycle).
REQ-023 READ -> HOLD unconditionally; sample_data <= mem_rdata on that edge; sample_valid=1 throughout HOLD.
REQ-024 Latency: sample_valid rises 2 cycles after tick.
REQ-025 HOLD: sample_data, sample_idx stable until sample_valid & sample_ready; on handshake sample_valid drops next cycle.
REQ-026 Handshake at sample_idx<LENGTH-1 -> sample_idx+1, WAIT_TICK.
REQ-027 Handshake at sample_idx==LENGTH-1: loop_en=1 -> sample_idx=0, WAIT_TICK; loop_en=0 -> DONE, done=1.
REQ-028 Ticks occurring in READ/HOLD are discarded (no queuing); next read waits for next tick.
REQ-029 stop in any busy state -> IDLE next cycle, sample_valid=0, mem_rd_en=0, sample_idx=0.
REQ-030 stop and start same cycle: stop wins; start ignored while busy.
REQ-031 loop_en sampled only at the last-sample handshake.

Reset
REQ-032 rst asserted: state=IDLE, all outputs 0, divider=0, within same cycle (asynchronous).
REQ-033 rst mid-playback: in-flight sample dropped, no handshake completes.

Configuration
REQ-034 Macro ECG_PLAYER_OVERRUN_CNT_EN defined: output overrun_cnt [15:0] counts ticks discarded per REQ-028, saturating at 16'hFFFF, cleared on rst and start.
REQ-035 Macro undefined: port overrun_cnt and counter absent; behaviour otherwise identical.

Structure
REQ-036 Package ecg_player_pkg holds state enum ecg_player_state_t and default constants (sample rate 360, default LENGTH 21600).
REQ-037 Sub-module ecg_rate_divider (parameter CLK_DIV; inputs clk, rst, clr, en; output tick) implements REQ-020.

Verification (LENGTH=4, CLK_DIV=5, memory = 10,20,30,40)
REQ-038 start, sample_ready=1, loop_en=0 -> samples 10,20,30,40 each 5 cycles apart, valid 2 cycles after tick, then done=1, busy=0.
REQ-039 sample_ready held 0 for 12 cycles on sample 20 -> sample_data=20 and sample_idx=1 stable throughout; next sample 30 follows first tick after handshake; overrun_cnt=2 with macro.
REQ-040 loop_en=1, ready=1 -> sequence 10,20,30,40,10,20; done never asserted.
REQ-041 stop during HOLD of sample 30 -> next cycle IDLE, sample_valid=0, sample_idx=0; later start restarts at 10.
REQ-042 rst pulse during READ -> all outputs 0 immediately, no sample_valid follows; start after release plays from 10.
REQ-043 start and stop same cycle from IDLE -> stays IDLE, busy=0.

Source files
------------

// File: rtl/ecg_player_pkg.sv
// rtl/ecg_player_pkg.sv - shared state type and default constants for the ECG sample player
package ecg_player_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        READ,
        HOLD,
        DONE
    } ecg_player_state_t;

    localparam int ECG_SAMPLE_RATE_HZ  = 360;
    localparam int ECG_DEFAULT_LENGTH  = 21600;
    localparam int ECG_DEFAULT_CLK_DIV = 277778;

    function automatic logic is_busy(input ecg_player_state_t s);
        return !(s == IDLE || s == DONE);
    endfunction

endpackage

// File: rtl/ecg_rate_divider.sv
// rtl/ecg_rate_divider.sv - free-running sample-period divider with a one-cycle terminal-count tick
module ecg_rate_divider #(
    parameter int CLK_DIV = 277778
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == TERM);

endmodule

// File: rtl/ecg_sample_player.sv
// rtl/ecg_sample_player.sv - paced playback of a recorded ECG from memory to a ready/valid consumer
// Define ECG_PLAYER_OVERRUN_CNT_EN to add the overrun_cnt output (ticks lost while a sample was pending).
module ecg_sample_player
    import ecg_player_pkg::*;
#(
    parameter int LENGTH     = ECG_DEFAULT_LENGTH,
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = $clog2(LENGTH),
    parameter int CLK_DIV    = ECG_DEFAULT_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic [ADDR_WIDTH-1:0] sample_idx,
    output logic                  busy,
    output logic                  done
`ifdef ECG_PLAYER_OVERRUN_CNT_EN
    ,
    output logic [15:0]           overrun_cnt
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LENGTH - 1);

    ecg_player_state_t     state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  fresh_q, fresh_d;
    logic                  busy_w, tick, start_acc;

    assign busy_w    = is_busy(state_q);
    assign start_acc = !busy_w && start && !stop;

    ecg_rate_divider #(.CLK_DIV(CLK_DIV)) u_rate_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (!busy_w),
        .en   (busy_w),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_acc) begin
                    state_d = WAIT_TICK;
                    idx_d   = '0;
                end
            end
            WAIT_TICK: if (tick) state_d = READ;
            READ:      state_d = HOLD;
            HOLD: begin
                if (sample_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = WAIT_TICK;
                    end else if (loop_en) begin
                        idx_d   = '0;
                        state_d = WAIT_TICK;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (busy_w && stop) begin
            state_d = IDLE;
            idx_d   = '0;
        end
        // Memory data lands in the first HOLD cycle; it is bypassed out then and latched for the rest of HOLD.
        if (fresh_q) data_d = mem_rdata;
        fresh_d = (state_q == READ) && (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            fresh_q <= fresh_d;
        end
    end

    assign mem_rd_en    = (state_q == READ);
    assign mem_addr     = mem_rd_en ? idx_q : '0;
    assign sample_valid = (state_q == HOLD);
    assign sample_data  = fresh_q ? mem_rdata : data_q;
    assign sample_idx   = idx_q;
    assign busy         = busy_w;
    assign done         = (state_q == DONE);

`ifdef ECG_PLAYER_OVERRUN_CNT_EN
    logic [15:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (start_acc) begin
            ovr_d = '0;
        end else if (tick && (state_q == READ || state_q == HOLD) && ovr_q != 16'hFFFF) begin
            ovr_d = ovr_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun_cnt = ovr_q;
`endif

endmodule
